// File: rtl/sensor_conditioner_if.sv
// Sensor-side and controller-side signals of the sensor conditioner.
// The slave modport is the conditioner. The master modport is its environment:
// the raw sensors, the Green lamps from Control, and Control reading the requests.
interface sensor_conditioner_if;
  logic NorthSensor;
  logic EastSensor;
  logic NorthGreen;
  logic EastGreen;
  logic NorthLevel;
  logic EastLevel;
  logic NorthReq;
  logic EastReq;

  modport master (
    output NorthSensor, EastSensor, NorthGreen, EastGreen,
    input  NorthLevel, EastLevel, NorthReq, EastReq
  );

  modport slave (
    input  NorthSensor, EastSensor, NorthGreen, EastGreen,
    output NorthLevel, EastLevel, NorthReq, EastReq
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Conditions the raw north/east vehicle sensors for the traffic Control FSM.
// Each channel has a 2-flop synchronizer, a debouncer driven by a shared sample
// tick, and a request latch. The latch holds a request until that direction's
// Green lamp acknowledges it. Index 0 is north and index 1 is east throughout.
module sensor_conditioner #(
  parameter int SAMPLE_DIV = 50000,  // clock cycles per debounce sample tick, >= 2
  parameter int DB_COUNT   = 20,     // consecutive disagreeing samples to flip, >= 1
  parameter int DIV_W      = 16,     // prescaler width, 2**DIV_W >= SAMPLE_DIV
  parameter int DB_W       = 5       // debounce counter width, 2**DB_W >= DB_COUNT
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_PB0,
  sensor_conditioner_if.slave   bus
);

  typedef enum logic {
    REQ_IDLE    = 1'b0,
    REQ_PENDING = 1'b1
  } req_state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_COUNT - 1);

  logic [1:0]       raw;
  logic [1:0]       ack;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       level_q;
  logic [1:0]       level_d;
  logic [1:0]       ack_q;
  logic [1:0]       rise;
  logic [DB_W-1:0]  cnt_q [2];
  logic [DB_W-1:0]  cnt_d [2];
  req_state_t       req_q [2];
  req_state_t       req_d [2];
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign raw = {bus.EastSensor, bus.NorthSensor};
  assign ack = {bus.EastGreen,  bus.NorthGreen};

  // Two-flop synchronizer for the asynchronous sensor inputs.
  // NOTE: every register in this block is reset asynchronously and written with
  // non-blocking assignments, so all flops sample their pre-edge inputs together.
  always_ff @(posedge CLOCK_50 or negedge reset_PB0) begin
    if (!reset_PB0) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Shared prescaler that counts 0..SAMPLE_DIV-1 and then wraps.
  always_ff @(posedge CLOCK_50 or negedge reset_PB0) begin
    if (!reset_PB0) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == DIV_LAST);

  // Debounce next-state logic: the level flips on the DB_COUNT-th consecutive
  // disagreeing tick. A single agreeing tick restarts the count.
  // NOTE: each output gets a default before any condition, so the block stays
  // purely combinational and cannot infer a latch.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      level_d[ch] = level_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      if (tick) begin
        if (sync2_q[ch] == level_q[ch]) begin
          cnt_d[ch] = '0;
        end else if (cnt_q[ch] == DB_LAST) begin
          level_d[ch] = sync2_q[ch];
          cnt_d[ch]   = '0;
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  // A rising debounced level raises the request on the same edge.
  assign rise = ~level_q & level_d;

  // Debounce state registers: level, sample counter and delayed acknowledge.
  always_ff @(posedge CLOCK_50 or negedge reset_PB0) begin
    if (!reset_PB0) begin
      level_q <= '0;
      ack_q   <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      level_q <= level_d;
      ack_q   <= ack;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  // Request latch next state. A held Green forces IDLE and beats a simultaneous
  // rise. A falling Green with the vehicle still present re-arms the request.
  // A falling level never clears a pending request.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      req_d[ch] = req_q[ch];
      if (ack[ch]) begin
        req_d[ch] = REQ_IDLE;
      end else begin
        case (req_q[ch])
          REQ_IDLE: begin
            if (rise[ch] || (ack_q[ch] && level_q[ch])) begin
              req_d[ch] = REQ_PENDING;
            end
          end
          REQ_PENDING: req_d[ch] = REQ_PENDING;
          default:     req_d[ch] = REQ_IDLE;
        endcase
      end
    end
  end

  // Request latch state register.
  always_ff @(posedge CLOCK_50 or negedge reset_PB0) begin
    if (!reset_PB0) begin
      for (int ch = 0; ch < 2; ch++) begin
        req_q[ch] <= REQ_IDLE;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        req_q[ch] <= req_d[ch];
      end
    end
  end

  assign bus.NorthLevel = level_q[0];
  assign bus.EastLevel  = level_q[1];
  assign bus.NorthReq   = (req_q[0] == REQ_PENDING);
  assign bus.EastReq    = (req_q[1] == REQ_PENDING);

endmodule
